// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and the hard-wired zero register number.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk_i clock, clr_i synchronous clear (wins over inc_i),
//        inc_i count enable, cnt_o current count (holds at all-ones).
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  // Stop at all-ones instead of wrapping
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles,
// whole-pipe freeze on outstanding dcache accesses, IF/ID flush on taken
// branches, sticky dcache timeout and saturating performance counters.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   id_rs_i/id_rt_i/id_uses_rt_i : source registers of the ID instruction
//   ex_memread_i/ex_rt_i         : load in EX and its destination
//   branch_taken_i               : branch resolved taken in ID
//   dcache_req_i/dcache_ready_i  : MEM stage access handshake
//   pc_enable_o, idex_enable_o, idex_bubble_o, pipe_hold_o, ifid_flush_o
//                                : pipeline register controls (Mealy)
//   mem_timeout_o                : sticky dcache timeout flag
//   stall_cycles_o, bubble_count_o : saturating counters
//   state_o                      : FSM state for debug
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             dcache_req_i,
  input  logic             dcache_ready_i,
  output logic             pc_enable_o,
  output logic             idex_enable_o,
  output logic             idex_bubble_o,
  output logic             pipe_hold_o,
  output logic             ifid_flush_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] bubble_count_o,
  output logic [1:0]       state_o
);

  localparam int unsigned WC_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((MEM_TIMEOUT == 0) ? 0 : (MEM_TIMEOUT - 1));

  hz_state_t       r_state;
  logic [WC_W-1:0] r_wait_cnt;
  logic            r_mem_timeout;

  logic w_load_use;
  logic w_mem_miss;
  logic w_freeze;
  logic w_stall_inc;
  logic w_bubble_inc;

  // Hazard detection; writes to $zero never create a dependency
  always_comb begin
    w_load_use = ex_memread_i && (ex_rt_i != REG_ZERO) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
    w_mem_miss = dcache_req_i && !dcache_ready_i;
  end

  // In MEM_WAIT the access is already outstanding, so only ready matters
  always_comb begin
    w_freeze = 1'b0;
    case (r_state)
      ST_RUN:      w_freeze = w_mem_miss;
      ST_MEM_WAIT: w_freeze = !dcache_ready_i;
      default:     w_freeze = 1'b0;
    endcase
  end

  // Mealy control outputs; flush only fires in an unstalled cycle
  always_comb begin
    pc_enable_o   = 1'b1;
    idex_enable_o = 1'b1;
    idex_bubble_o = 1'b0;
    pipe_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    if (rst_i) begin
      idex_bubble_o = 1'b1;
      ifid_flush_o  = 1'b1;
    end else if ((r_state != ST_RUN) && (r_state != ST_MEM_WAIT)) begin
      pc_enable_o   = 1'b0;
      idex_enable_o = 1'b0;
      pipe_hold_o   = 1'b1;
    end else if (w_freeze) begin
      pc_enable_o   = 1'b0;
      idex_enable_o = 1'b0;
      pipe_hold_o   = 1'b1;
    end else if (w_load_use) begin
      pc_enable_o   = 1'b0;
      idex_bubble_o = 1'b1;
    end else begin
      ifid_flush_o  = branch_taken_i;
    end
  end

  // State, wait counter and sticky timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_miss) begin
            r_state    <= ST_MEM_WAIT;
            r_wait_cnt <= WC_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dcache_ready_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if ((MEM_TIMEOUT != 0) && (r_wait_cnt >= WC_LAST)) begin
            r_state       <= ST_HALT;
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WC_W'(1);
          end
        end
        ST_HALT: begin
          r_state <= ST_HALT;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // HALT stalls are not counted; reset-time bubbles are not counted
  assign w_stall_inc  = !pc_enable_o && (r_state != ST_HALT);
  assign w_bubble_inc = idex_bubble_o && !rst_i;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (w_stall_inc),
    .cnt_o (stall_cycles_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (w_bubble_inc),
    .cnt_o (bubble_count_o)
  );

  assign mem_timeout_o = r_mem_timeout;
  assign state_o       = r_state;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned T_OUT = 4;
  localparam int unsigned CW    = 8;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread, branch_taken, dcache_req, dcache_ready;
  logic          pc_en, idex_en, bubble, hold, flush, timeout;
  logic [CW-1:0] stall_cnt, bub_cnt;
  logic [1:0]    state;

  int total = 0;
  int bad   = 0;

  // Model: frozen cycles since the access went outstanding, halted/waiting flags
  bit m_known  = 0;
  bit m_halt   = 0;
  bit m_wait   = 0;
  bit m_to     = 0;
  int m_frozen = 0;
  int m_stall  = 0;
  int m_bub    = 0;

  hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .ex_memread_i   (ex_memread),
    .ex_rt_i        (ex_rt),
    .branch_taken_i (branch_taken),
    .dcache_req_i   (dcache_req),
    .dcache_ready_i (dcache_ready),
    .pc_enable_o    (pc_en),
    .idex_enable_o  (idex_en),
    .idex_bubble_o  (bubble),
    .pipe_hold_o    (hold),
    .ifid_flush_o   (flush),
    .mem_timeout_o  (timeout),
    .stall_cycles_o (stall_cnt),
    .bubble_count_o (bub_cnt),
    .state_o        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare at the falling edge, then advance the model
  task automatic cyc(input bit r, input int rs, input int rt, input bit uses,
                     input bit mr, input int xrt, input bit br, input bit req, input bit rdy);
    bit lu, frz, e_pc, e_ie, e_bu, e_ho, e_fl;
    int e_st;
    @(posedge clk);
    #1;
    rst = r; id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses;
    ex_memread = mr; ex_rt = 5'(xrt); branch_taken = br;
    dcache_req = req; dcache_ready = rdy;
    @(negedge clk);

    lu  = mr && (xrt != 0) && ((xrt == rs) || (uses && (xrt == rt)));
    frz = m_wait ? !rdy : (req && !rdy);
    if (r) begin
      e_pc = 1; e_ie = 1; e_bu = 1; e_ho = 0; e_fl = 1;
    end else if (m_halt || frz) begin
      e_pc = 0; e_ie = 0; e_bu = 0; e_ho = 1; e_fl = 0;
    end else if (lu) begin
      e_pc = 0; e_ie = 1; e_bu = 1; e_ho = 0; e_fl = 0;
    end else begin
      e_pc = 1; e_ie = 1; e_bu = 0; e_ho = 0; e_fl = br;
    end
    e_st = m_halt ? 2 : (m_wait ? 1 : 0);

    check_val("pc_enable", 32'(pc_en), 32'(e_pc));
    check_val("idex_enable", 32'(idex_en), 32'(e_ie));
    check_val("idex_bubble", 32'(bubble), 32'(e_bu));
    check_val("pipe_hold", 32'(hold), 32'(e_ho));
    check_val("ifid_flush", 32'(flush), 32'(e_fl));
    if (m_known) begin
      check_val("state", 32'(state), 32'(e_st));
      check_val("mem_timeout", 32'(timeout), 32'(m_to));
      check_val("stall_cycles", 32'(stall_cnt), 32'(m_stall));
      check_val("bubble_count", 32'(bub_cnt), 32'(m_bub));
    end

    if (r) begin
      m_known = 1; m_halt = 0; m_wait = 0; m_to = 0;
      m_frozen = 0; m_stall = 0; m_bub = 0;
    end else if (!m_halt) begin
      if (!e_pc && m_stall < CMAX) m_stall++;
      if (e_bu && m_bub < CMAX) m_bub++;
      if (frz) begin
        m_frozen++;
        if (m_frozen >= int'(T_OUT)) begin
          m_halt = 1; m_to = 1; m_wait = 0;
        end else begin
          m_wait = 1;
        end
      end else begin
        m_wait = 0; m_frozen = 0;
      end
    end
  endtask

  task automatic idle();
    cyc(0, 1, 2, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_memread = 0;
    ex_rt = 0; branch_taken = 0; dcache_req = 0; dcache_ready = 0;

    // Reset, then a single load-use bubble
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 8, 0, 0, 1, 8, 0, 0, 0);
    cyc(0, 8, 0, 0, 0, 8, 0, 0, 0);
    idle();
    check_val("lu_bubble_count", 32'(bub_cnt), 32'd1);
    check_val("lu_stall_cycles", 32'(stall_cnt), 32'd1);

    // $zero destination never stalls; sw consumer matches on rt
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0);
    cyc(0, 3, 9, 1, 1, 9, 0, 0, 0);
    cyc(0, 3, 9, 0, 1, 9, 0, 0, 0);
    idle();

    // Three frozen cycles then release on ready
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 1, 1);
    idle();
    check_val("miss_stall_cycles", 32'(stall_cnt), 32'd3);
    check_val("miss_timeout", 32'(timeout), 32'd0);

    // Timeout into HALT, HALT persists, reset recovers
    repeat (8) cyc(0, 1, 2, 0, 0, 0, 1, 1, 0);
    check_val("halt_state", 32'(state), 32'd2);
    check_val("halt_timeout", 32'(timeout), 32'd1);
    cyc(0, 1, 2, 0, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    check_val("post_halt_state", 32'(state), 32'd0);
    check_val("post_halt_timeout", 32'(timeout), 32'd0);

    // Branch held back while stalled, flushed on the first free cycle
    cyc(0, 5, 0, 0, 1, 5, 1, 0, 0);
    cyc(0, 5, 0, 0, 0, 5, 1, 0, 0);
    cyc(0, 1, 2, 0, 0, 0, 1, 1, 0);
    cyc(0, 1, 2, 0, 0, 0, 1, 1, 0);
    cyc(0, 1, 2, 0, 0, 0, 1, 1, 1);
    idle();

    // Reset mid-wait, then a fresh miss takes the full timeout
    cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
    cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 2, 0, 0, 0, 1, 1, 0);
    repeat (3) cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
    check_val("after_rst_no_halt", 32'(state), 32'd1);
    repeat (2) cyc(0, 1, 2, 0, 0, 0, 0, 1, 0);
    check_val("after_rst_halt", 32'(state), 32'd2);

    // Counter saturation on a long load-use run
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (300) cyc(0, 7, 0, 0, 1, 7, 0, 0, 0);
    idle();
    check_val("sat_stall", 32'(stall_cnt), 32'(CMAX));
    check_val("sat_bubble", 32'(bub_cnt), 32'(CMAX));
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic with small register indices to provoke matches
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(99) < 2),
          int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom),
          ($urandom_range(99) < 35), int'($urandom_range(3)), 1'($urandom),
          ($urandom_range(99) < 30), ($urandom_range(99) < 50));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline stall/flush controller for the 5-stage MIPS core. It drives the hold and enable inputs of the pipeline registers, including the ID/EX register's enable, and it consumes that register's MemRead and rt outputs.
- Detects load-use hazards and inserts a one-cycle bubble into ID/EX.
- Freezes the whole pipe while a data-cache access is outstanding.
- Flushes IF/ID on a taken branch.
- Latches a sticky timeout error and keeps saturating stall/bubble counters for performance analysis.

Parameters:
- MEM_TIMEOUT, 16: max consecutive frozen cycles waiting on dcache before HALT; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- id_rs_i  in  5  IF/ID inst[25:21]
- id_rt_i  in  5  IF/ID inst[20:16]
- id_uses_rt_i  in  1  ID instruction reads rt as a source (R-type, beq, sw)
- ex_memread_i  in  1  ID/EX MemRead control bit
- ex_rt_i  in  5  ID/EX inst20_16 (load destination)
- branch_taken_i  in  1  branch resolved taken in ID
- dcache_req_i  in  1  MEM stage has a load/store this cycle
- dcache_ready_i  in  1  dcache completes the access this cycle
- pc_enable_o  out  1  PC and IF/ID write enable
- idex_enable_o  out  1  ID/EX enable (drives its pcEnable_i)
- idex_bubble_o  out  1  zero WB/M/EX controls entering ID/EX
- pipe_hold_o  out  1  hold EX/MEM and MEM/WB
- ifid_flush_o  out  1  clear IF/ID instruction to NOP
- mem_timeout_o  out  1  sticky; dcache timeout occurred
- stall_cycles_o  out  CNT_W  cycles with pc_enable_o=0 (saturating)
- bubble_count_o  out  CNT_W  bubbles inserted (saturating)
- state_o  out  2  FSM state (debug)

Behaviour:

State register:
- States are RUN=0, MEM_WAIT=1, HALT=2.
- Only the state, wait_cnt, mem_timeout_o and the counters are registered. The control outputs are combinational from state and inputs (Mealy).

Hazard definitions:
- load_use = ex_memread_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_uses_rt_i && ex_rt_i==id_rt_i)).
- mem_miss = dcache_req_i && !dcache_ready_i.

While rst_i=1:
- Outputs: pc_enable_o=1, idex_enable_o=1, idex_bubble_o=1, ifid_flush_o=1, pipe_hold_o=0, so the pipe fills with NOPs.
- On the edge: state<=RUN, wait_cnt<=0, mem_timeout_o<=0, both counters<=0.
- Reset mid-MEM_WAIT or in HALT behaves identically.

RUN, priority order:
1. mem_miss: pc_enable=0, idex_enable=0, pipe_hold=1, bubble=0, flush=0. Next state MEM_WAIT, wait_cnt<=1.
2. load_use: pc_enable=0, idex_enable=1, bubble=1, pipe_hold=0, flush=0. Stay in RUN. The load advances and the consumer is re-evaluated next cycle.
3. Otherwise: all enables 1, pipe_hold=0, bubble=0, flush=branch_taken_i.

Flush rule:
- Flush is suppressed in every stalled cycle. The branch stays in ID and is re-resolved on release.

MEM_WAIT:
- dcache_ready_i=1: outputs are evaluated exactly as RUN items 2-3. The ready cycle is the release cycle, and MEM/WB captures the data on it. Next state RUN, wait_cnt<=0.
- Else, outputs are frozen as in RUN item 1.
  - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT-1: next state HALT, mem_timeout_o<=1.
  - Otherwise wait_cnt<=wait_cnt+1.
- Net effect: exactly MEM_TIMEOUT frozen cycles without ready precede HALT.

HALT:
- Outputs: all enables 0, pipe_hold=1, bubble=0, flush=0.
- Exit only via rst_i.

Counters:
- stall_cycles_o increments on each cycle with pc_enable_o=0 and state!=HALT.
- bubble_count_o increments on each cycle with idex_bubble_o=1 and rst_i=0.
- Both saturate at all-ones; no wrap.

Width rule:
- wait_cnt is $clog2(MEM_TIMEOUT+1) bits, minimum 1.

Decomposition:
- hazard_pkg holds the state encoding (RUN/MEM_WAIT/HALT) and REG_ZERO=5'd0.
- One natural sub-module: sat_counter (CNT_W, inc, synchronous clear), instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
1. lw $8 in EX (ex_memread=1, ex_rt=8); ID add with rs=8 -> exactly one cycle with pc_enable=0, idex_enable=1, bubble=1; next cycle (ex_memread=0) all enables 1; bubble_count=1, stall_cycles=1.
2. ex_rt=0 with ex_memread=1 and id_rs=0; also a sw consumer with id_uses_rt=1 and rt match -> first case: no stall; second case: one bubble.
3. dcache_req=1, ready low for 3 cycles then high -> 3 frozen cycles (pipe_hold=1, state_o=1), release on the ready cycle, stall_cycles=3, mem_timeout=0.
4. MEM_TIMEOUT=4, ready never asserted -> 4 frozen cycles, then state_o=2 and mem_timeout_o=1 from cycle 5; HALT persists; rst_i for one cycle -> RUN, counters=0, timeout=0.
5. branch_taken=1 concurrent with load_use, then with mem_miss -> flush=0 while stalled; flush=1 on the first unstalled cycle.
6. rst_i asserted mid-MEM_WAIT -> during reset: enables=1, bubble=1, flush=1; after reset: state_o=0, wait_cnt cleared, and a subsequent miss takes the full timeout.
